regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised register file with configurable data width, depth and read-port count, combinational read, optional write-through bypass, and a per-register scoreboard of pending-write (busy) bits. It is the next-generation register file for the processor datapath. The pipeline uses it to read operands and to learn whether each operand is still awaiting a producer. Register 0 is hardwired to zero and is never busy.

## Interface
Parameters:
- DATA_WIDTH, 32, bits per register
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
- NUM_READ, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write is visible on reads; 0 = reads return the pre-write value

Ports:
- clock  in  1  single clock; all state updates on rising edge
- ctrl_reset  in  1  reset, synchronous, active-high
- ctrl_writeEnable  in  1  commit data_writeReg to ctrl_writeReg this edge
- ctrl_writeReg  in  ADDR_WIDTH  write index
- data_writeReg  in  DATA_WIDTH  write data
- ctrl_reserveEnable  in  1  mark ctrl_reserveReg busy (issue of a producer)
- ctrl_reserveReg  in  ADDR_WIDTH  reserve index
- ctrl_readReg  in  NUM_READ*ADDR_WIDTH  read indices; port k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- data_readReg  out  NUM_READ*DATA_WIDTH  read data; port k uses bits [k*DATA_WIDTH +: DATA_WIDTH]
- data_readValid  out  NUM_READ  1 = port k data is final (register not busy, or bypassed)
- ctrl_debugReg  in  ADDR_WIDTH  debug/observation index
- data_debugReg  out  DATA_WIDTH  debug read of ctrl_debugReg, never bypassed
- busy_count  out  ADDR_WIDTH+1  number of registers currently busy

## Operation
- Storage: regs[1..DEPTH-1] of DATA_WIDTH bits each, plus busy[1..DEPTH-1]. Index 0 has no storage and always reads 0 with valid=1.
- Write: on an edge with ctrl_writeEnable=1 and ctrl_writeReg!=0, regs[ctrl_writeReg] <= data_writeReg and busy[ctrl_writeReg] <= 0. A write to index 0 is discarded.
- Reserve: on an edge with ctrl_reserveEnable=1 and ctrl_reserveReg!=0, busy[ctrl_reserveReg] <= 1. Reserving an already-busy register leaves it busy and is not an error.
- Write and reserve to the same index in the same cycle: the data is stored and busy ends at 1 (the newer producer wins). Different indices: both take effect.
- Read port k, index a, combinational:
  - a==0 -> data 0, valid 1.
  - BYPASS=1 and ctrl_writeEnable and ctrl_writeReg==a -> data = data_writeReg, valid 1.
  - Otherwise -> data = regs[a], valid = ~busy[a].
- All read ports are independent. Any number of ports may address the same index.
- busy_count = popcount(busy), registered: it reflects the state after the last edge.
- Reset: on an edge with ctrl_reset=1, all regs <= 0, all busy <= 0, busy_count <= 0. Reset overrides a same-cycle write or reserve.

## Timing
- Read latency: 0 cycles (combinational from ctrl_readReg and state). A write is visible to non-bypassed reads one edge after commit.
- Scoreboard latency: a reserve at edge N makes valid=0 from just after N. A write at edge M makes valid=1 combinationally during cycle M when BYPASS=1, and from just after M in either mode.
- Reset values, one edge after ctrl_reset=1: every data_readReg = 0, every data_readValid = 1, data_debugReg = 0, busy_count = 0.
- Reset asserted in mid-sequence discards pending busy bits. No write can be outstanding afterwards.
- No handshakes: write and reserve are single-cycle strobes, accepted unconditionally.

## Test plan
- Reset, then read all indices on every port -> every data 0, valid 1, busy_count 0.
- Write 0xDEADBEEF to r5, read r5 on port 0 and port 1 in the next cycle -> both 0xDEADBEEF, valid 1. Write 0x1234 to r0 -> r0 still reads 0.
- BYPASS=1: write 0xA5A5A5A5 to r7 while port 0 reads r7 in the same cycle -> port 0 shows 0xA5A5A5A5 and data_debugReg(r7) shows the old value. Repeat with BYPASS=0 -> port 0 shows the old value.
- Reserve r3 -> valid[r3]=0 and busy_count=1. Write 0x55 to r3 -> valid=1 with data 0x55 and busy_count=0. Reserve r0 -> busy_count stays 0.
- Same-cycle write 0x99 to r4 and reserve of r4 -> next cycle data 0x99, valid 0, busy_count 1.
- Reserve r1, r2 and r31, write r9=0x77, then assert ctrl_reset alongside a write of r9=0x88 -> busy_count 0, r9 reads 0, all valid 1.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy scoreboard; r0 hardwired to zero and never busy.
// Latency: reads and debug are combinational; writes, reserves and busy_count update on the rising edge.
// Backpressure: none; write and reserve strobes are accepted unconditionally every cycle.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int BYPASS     = 1
) (
    input  logic                           clock,
    input  logic                           ctrl_reset,
    input  logic                           ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0]          ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0]          data_writeReg,
    input  logic                           ctrl_reserveEnable,
    input  logic [ADDR_WIDTH-1:0]          ctrl_reserveReg,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] ctrl_readReg,
    output logic [NUM_READ*DATA_WIDTH-1:0] data_readReg,
    output logic [NUM_READ-1:0]            data_readValid,
    input  logic [ADDR_WIDTH-1:0]          ctrl_debugReg,
    output logic [DATA_WIDTH-1:0]          data_debugReg,
    output logic [ADDR_WIDTH:0]            busy_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Entry 0 is held at zero by reset and never written, so it folds to a constant.
    logic [DATA_WIDTH-1:0] regs [0:DEPTH-1];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      busy_nxt;
    logic [ADDR_WIDTH:0]   busy_count_nxt;
    logic                  wr_hit;
    logic                  rsv_hit;

    assign wr_hit  = ctrl_writeEnable   && (ctrl_writeReg   != '0);
    assign rsv_hit = ctrl_reserveEnable && (ctrl_reserveReg != '0);

    // Reserve is applied after the write clear so a same-index collision leaves the newer producer pending.
    always_comb begin
        busy_nxt = busy;
        if (wr_hit) begin
            busy_nxt[ctrl_writeReg] = 1'b0;
        end
        if (rsv_hit) begin
            busy_nxt[ctrl_reserveReg] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        busy_count_nxt = '0;
        for (int i = 1; i < DEPTH; i++) begin
            busy_count_nxt = busy_count_nxt + {{ADDR_WIDTH{1'b0}}, busy_nxt[i]};
        end
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy       <= '0;
            busy_count <= '0;
        end else begin
            if (wr_hit) begin
                regs[ctrl_writeReg] <= data_writeReg;
            end
            busy       <= busy_nxt;
            busy_count <= busy_count_nxt;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] rd_idx;
        logic [DATA_WIDTH-1:0] rd_dat;
        logic                  rd_vld;

        assign rd_idx = ctrl_readReg[k*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            rd_dat = regs[rd_idx];
            rd_vld = ~busy[rd_idx];
            if (rd_idx == '0) begin
                rd_dat = '0;
                rd_vld = 1'b1;
            end else if ((BYPASS != 0) && ctrl_writeEnable && (ctrl_writeReg == rd_idx)) begin
                rd_dat = data_writeReg;
                rd_vld = 1'b1;
            end
        end

        assign data_readReg[k*DATA_WIDTH +: DATA_WIDTH] = rd_dat;
        assign data_readValid[k]                        = rd_vld;
    end

    // Debug view shows committed state only, so it can observe the pre-write value under bypass.
    assign data_debugReg = (ctrl_debugReg == '0) ? '0 : regs[ctrl_debugReg];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench driving a bypassed and a non-bypassed register file from the same stimulus.
module tb_regfile_scoreboard;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic        ctrl_reserveEnable;
    logic [4:0]  ctrl_reserveReg;
    logic [9:0]  ctrl_readReg;
    logic [4:0]  ctrl_debugReg;

    logic [63:0] rd_dat_b, rd_dat_n;
    logic [1:0]  rd_vld_b, rd_vld_n;
    logic [31:0] dbg_b, dbg_n;
    logic [5:0]  cnt_b, cnt_n;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .BYPASS(1)) u_byp (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
        .ctrl_reserveEnable(ctrl_reserveEnable), .ctrl_reserveReg(ctrl_reserveReg),
        .ctrl_readReg(ctrl_readReg), .data_readReg(rd_dat_b), .data_readValid(rd_vld_b),
        .ctrl_debugReg(ctrl_debugReg), .data_debugReg(dbg_b), .busy_count(cnt_b)
    );

    regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .BYPASS(0)) u_nb (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
        .ctrl_reserveEnable(ctrl_reserveEnable), .ctrl_reserveReg(ctrl_reserveReg),
        .ctrl_readReg(ctrl_readReg), .data_readReg(rd_dat_n), .data_readValid(rd_vld_n),
        .ctrl_debugReg(ctrl_debugReg), .data_debugReg(dbg_n), .busy_count(cnt_n)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs then change well away from it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        ctrl_readReg = {a1, a0};
        #1;
    endtask

    initial begin
        ctrl_reset         = 1'b1;
        ctrl_writeEnable   = 1'b0;
        ctrl_writeReg      = '0;
        data_writeReg      = '0;
        ctrl_reserveEnable = 1'b0;
        ctrl_reserveReg    = '0;
        ctrl_readReg       = '0;
        ctrl_debugReg      = '0;
        tick();
        ctrl_reset = 1'b0;

        // Reset state on every index and both ports
        chk("rst_cnt_b", cnt_b, 0);
        chk("rst_cnt_n", cnt_n, 0);
        for (int a = 0; a < 32; a++) begin
            rd(a[4:0], 5'(31 - a));
            ctrl_debugReg = a[4:0];
            #1;
            chk("rst_dat_b", rd_dat_b, 0);
            chk("rst_vld_b", rd_vld_b, 2'b11);
            chk("rst_dat_n", rd_dat_n, 0);
            chk("rst_vld_n", rd_vld_n, 2'b11);
            chk("rst_dbg", dbg_b, 0);
        end

        // Plain write then read on both ports
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd5; data_writeReg = 32'hDEADBEEF;
        tick();
        ctrl_writeEnable = 1'b0;
        rd(5'd5, 5'd5);
        chk("r5_dat_b", rd_dat_b, 64'hDEADBEEF_DEADBEEF);
        chk("r5_vld_b", rd_vld_b, 2'b11);
        chk("r5_dat_n", rd_dat_n, 64'hDEADBEEF_DEADBEEF);

        // Write to r0 is discarded
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd0; data_writeReg = 32'h1234;
        rd(5'd0, 5'd0);
        chk("r0_byp_dat", rd_dat_b, 0);
        tick();
        ctrl_writeEnable = 1'b0;
        ctrl_debugReg = 5'd0;
        rd(5'd0, 5'd5);
        chk("r0_dat_b", rd_dat_b, 64'hDEADBEEF_00000000);
        chk("r0_vld_b", rd_vld_b, 2'b11);
        chk("r0_dbg", dbg_b, 0);
        chk("r0_cnt", cnt_b, 0);

        // Bypass versus no bypass on a same-cycle write to r7
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd7; data_writeReg = 32'h11111111;
        tick();
        data_writeReg = 32'hA5A5A5A5;
        ctrl_debugReg = 5'd7;
        rd(5'd7, 5'd5);
        chk("byp_dat_b", rd_dat_b, 64'hDEADBEEF_A5A5A5A5);
        chk("byp_vld_b", rd_vld_b, 2'b11);
        chk("byp_dbg_b", dbg_b, 32'h11111111);
        chk("nbyp_dat_n", rd_dat_n, 64'hDEADBEEF_11111111);
        chk("nbyp_dbg_n", dbg_n, 32'h11111111);
        tick();
        ctrl_writeEnable = 1'b0;
        #1;
        chk("r7_dat_n", rd_dat_n, 64'hDEADBEEF_A5A5A5A5);
        chk("r7_dbg_b", dbg_b, 32'hA5A5A5A5);

        // Reserve r3, then resolve it with a write
        ctrl_reserveEnable = 1'b1; ctrl_reserveReg = 5'd3;
        tick();
        ctrl_reserveEnable = 1'b0;
        rd(5'd3, 5'd0);
        chk("rsv3_vld_b", rd_vld_b, 2'b10);
        chk("rsv3_cnt_b", cnt_b, 1);
        chk("rsv3_vld_n", rd_vld_n, 2'b10);
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd3; data_writeReg = 32'h55;
        #1;
        chk("wr3_byp_vld_b", rd_vld_b, 2'b11);
        chk("wr3_byp_dat_b", rd_dat_b, 64'h55);
        chk("wr3_nbyp_vld_n", rd_vld_n, 2'b10);
        chk("wr3_nbyp_dat_n", rd_dat_n, 64'h0);
        tick();
        ctrl_writeEnable = 1'b0;
        #1;
        chk("wr3_vld_n", rd_vld_n, 2'b11);
        chk("wr3_dat_n", rd_dat_n, 64'h55);
        chk("wr3_cnt_b", cnt_b, 0);

        // Reserve of r0 is ignored
        ctrl_reserveEnable = 1'b1; ctrl_reserveReg = 5'd0;
        tick();
        ctrl_reserveEnable = 1'b0;
        rd(5'd0, 5'd0);
        chk("rsv0_cnt_b", cnt_b, 0);
        chk("rsv0_vld_b", rd_vld_b, 2'b11);

        // Same-index write and reserve: data stored, busy wins
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd4; data_writeReg = 32'h99;
        ctrl_reserveEnable = 1'b1; ctrl_reserveReg = 5'd4;
        tick();
        ctrl_writeEnable = 1'b0; ctrl_reserveEnable = 1'b0;
        rd(5'd4, 5'd4);
        chk("wr_rsv4_dat_b", rd_dat_b, 64'h00000099_00000099);
        chk("wr_rsv4_vld_b", rd_vld_b, 2'b00);
        chk("wr_rsv4_cnt_b", cnt_b, 1);
        chk("wr_rsv4_cnt_n", cnt_n, 1);

        // Different indices in one cycle: both take effect
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd4; data_writeReg = 32'hAA;
        ctrl_reserveEnable = 1'b1; ctrl_reserveReg = 5'd6;
        tick();
        ctrl_writeEnable = 1'b0;
        ctrl_reserveReg = 5'd6;
        rd(5'd4, 5'd6);
        chk("split_dat_b", rd_dat_b[31:0], 32'hAA);
        chk("split_vld_b", rd_vld_b, 2'b01);
        chk("split_cnt_b", cnt_b, 1);
        // Re-reserving an already busy register keeps it busy and the count unchanged
        tick();
        ctrl_reserveEnable = 1'b0;
        #1;
        chk("rersv_cnt_b", cnt_b, 1);
        chk("rersv_vld_b", rd_vld_b, 2'b01);

        // Build up several busy bits, then reset over a same-cycle write
        ctrl_reserveEnable = 1'b1; ctrl_reserveReg = 5'd1;
        tick();
        ctrl_reserveReg = 5'd2;
        tick();
        ctrl_reserveReg = 5'd31;
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd9; data_writeReg = 32'h77;
        tick();
        ctrl_reserveEnable = 1'b0; ctrl_writeEnable = 1'b0;
        rd(5'd9, 5'd31);
        chk("pre_rst_cnt_b", cnt_b, 4);
        chk("pre_rst_dat_b", rd_dat_b[31:0], 32'h77);
        chk("pre_rst_vld_b", rd_vld_b, 2'b01);

        ctrl_reset = 1'b1;
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd9; data_writeReg = 32'h88;
        tick();
        ctrl_reset = 1'b0; ctrl_writeEnable = 1'b0;
        ctrl_debugReg = 5'd9;
        rd(5'd9, 5'd9);
        chk("post_rst_cnt_b", cnt_b, 0);
        chk("post_rst_cnt_n", cnt_n, 0);
        chk("post_rst_dat_b", rd_dat_b, 0);
        chk("post_rst_dbg_b", dbg_b, 0);
        for (int a = 0; a < 32; a++) begin
            rd(a[4:0], a[4:0]);
            chk("post_rst_vld_b", rd_vld_b, 2'b11);
            chk("post_rst_vld_n", rd_vld_n, 2'b11);
            chk("post_rst_all_dat", rd_dat_n, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
